// File: rtl/obs_sched_pkg.sv
// Shared types and constants for the obs_mul_sched multiplier scheduler.
package obs_sched_pkg;

   localparam int FIELD_W = 131;
   localparam int PROD_W  = 2 * FIELD_W - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Ceiling log2 for elaboration-time widths; returns 0 for n <= 1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/obs_mul_sched_if.sv
// Request/response bundle between field-arithmetic clients and obs_mul_sched.
// Requester i occupies bits [i*FIELD_W +: FIELD_W] of req_a/req_b.
interface obs_mul_sched_if #(
   parameter int NREQ = 4
);
   import obs_sched_pkg::*;

   localparam int ID_W = clog2(NREQ);

   logic [NREQ-1:0]         req_valid;
   logic [NREQ-1:0]         req_ready;
   logic [NREQ*FIELD_W-1:0] req_a;
   logic [NREQ*FIELD_W-1:0] req_b;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [PROD_W-1:0]       rsp_data;
   logic [ID_W-1:0]         rsp_id;
   logic                    busy;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id, busy
   );

endinterface

// File: rtl/OKA_131bit.sv
// Combinational 131x131 carry-less (GF(2)[x]) multiplier, 261-bit product.
module OKA_131bit (
   input  logic [130:0] a,
   input  logic [130:0] b,
   output logic [260:0] y
);

   // XOR-accumulate shifted copies of a for every set bit of b.
   always_comb begin
      y = '0;
      for (int i = 0; i < 131; i++) begin
         if (b[i]) y = y ^ ({130'd0, a} << i);
      end
   end

endmodule

// File: rtl/obs_rr_arb.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i,
// wrapping at NREQ-1 -> 0. grant_o is one-hot or zero.
module obs_rr_arb #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [ID_W-1:0] gnt_idx_o,
   output logic            gnt_vld_o
);

   // Scan NREQ candidates starting at the pointer; the first hit wins.
   always_comb begin
      int idx;
      logic [ID_W-1:0] cand;
      grant_o   = '0;
      gnt_idx_o = '0;
      gnt_vld_o = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_i) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         cand = ID_W'(idx);
         if (!gnt_vld_o && req_i[cand]) begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = cand;
         end
      end
      if (gnt_vld_o) grant_o[gnt_idx_o] = 1'b1;
   end

endmodule

// File: rtl/obs_mul_sched.sv
// obs_mul_sched: shares one OKA_131bit between NREQ requesters with
// round-robin arbitration. Operands are registered and held for MUL_CYCLES
// cycles (multicycle path into the multiplier) before the product is captured.
// Optional: define OBS_SCHED_PERF_EN to add perf_done/perf_stall counters.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | arbitrate; grant accepted -> latch operands and id, go WAIT
//  WAIT  | operands frozen, count MUL_CYCLES down, capture product
//  RESP  | rsp_valid high, product/id held until rsp_ready
module obs_mul_sched
   import obs_sched_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int MUL_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   obs_mul_sched_if.slave bus
`ifdef OBS_SCHED_PERF_EN
   ,
   output logic [31:0] perf_done,
   output logic [31:0] perf_stall
`endif
);

   localparam int ID_W  = clog2(NREQ);
   localparam int CNT_W = clog2(MUL_CYCLES + 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [FIELD_W-1:0] opa_q, opa_d;
   logic [FIELD_W-1:0] opb_q, opb_d;
   logic [PROD_W-1:0]  data_q, data_d;
   logic               vld_q, vld_d;
   logic [NREQ-1:0]    req_ready_c;

   logic [NREQ-1:0]    arb_grant;
   logic [ID_W-1:0]    arb_idx;
   logic               arb_vld;
   logic [PROD_W-1:0]  mul_y;

   logic [FIELD_W-1:0] a_arr [NREQ];
   logic [FIELD_W-1:0] b_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign a_arr[g] = bus.req_a[g*FIELD_W +: FIELD_W];
      assign b_arr[g] = bus.req_b[g*FIELD_W +: FIELD_W];
   end

   obs_rr_arb #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_arb (
      .req_i     (bus.req_valid),
      .ptr_i     (ptr_q),
      .grant_o   (arb_grant),
      .gnt_idx_o (arb_idx),
      .gnt_vld_o (arb_vld)
   );

   // The multiplier sees only the frozen operand registers.
   OKA_131bit u_mul (
      .a (opa_q),
      .b (opb_q),
      .y (mul_y)
   );

   // State, operand, and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         id_q    <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         data_q  <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
      end
   end

   // Next-state and grant logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      data_d      = data_q;
      vld_d       = vld_q;
      req_ready_c = '0;
      case (state_q)
         IDLE: begin
            if (arb_vld) begin
               req_ready_c = arb_grant;
               opa_d       = a_arr[arb_idx];
               opb_d       = b_arr[arb_idx];
               id_d        = arb_idx;
               ptr_d       = (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
               cnt_d       = CNT_W'(MUL_CYCLES - 1);
               state_d     = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               data_d  = mul_y;
               vld_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               vld_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // No grant is visible while reset is held.
   assign bus.req_ready = rst_n ? req_ready_c : '0;
   assign bus.rsp_valid = vld_q;
   assign bus.rsp_data  = data_q;
   assign bus.rsp_id    = id_q;
   assign bus.busy      = (state_q != IDLE);

`ifdef OBS_SCHED_PERF_EN
   logic [31:0] perf_done_q;
   logic [31:0] perf_stall_q;

   // Saturating counts of response handshakes and back-pressured RESP cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_done_q  <= '0;
         perf_stall_q <= '0;
      end else if (state_q == RESP) begin
         if (bus.rsp_ready) begin
            if (perf_done_q != '1) perf_done_q <= perf_done_q + 32'd1;
         end else begin
            if (perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_done  = perf_done_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_obs_mul_sched.sv
// Self-checking bench for obs_mul_sched (NREQ=4, MUL_CYCLES=2).
// Expected responses go into a scoreboard queue when requests are queued,
// and a monitor pops and compares them on every response handshake.
module tb_obs_mul_sched;
   import obs_sched_pkg::*;

   localparam int NREQ = 4;
   localparam int ID_W = 2;

   logic clk;
   logic rst_n;

   obs_mul_sched_if #(.NREQ(NREQ)) bus ();

`ifdef OBS_SCHED_PERF_EN
   logic [31:0] perf_done;
   logic [31:0] perf_stall;
`endif

   obs_mul_sched #(
      .NREQ       (NREQ),
      .MUL_CYCLES (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef OBS_SCHED_PERF_EN
      ,
      .perf_done  (perf_done),
      .perf_stall (perf_stall)
`endif
   );

   typedef struct {
      logic [ID_W-1:0]   id;
      logic [PROD_W-1:0] data;
   } exp_t;

   exp_t               exp_q [$];
   logic [FIELD_W-1:0] qa [NREQ][$];
   logic [FIELD_W-1:0] qb [NREQ][$];

   logic               drv_v [NREQ];
   logic [FIELD_W-1:0] drv_a [NREQ];
   logic [FIELD_W-1:0] drv_b [NREQ];

   int pass_cnt = 0;
   int tot_cnt  = 0;
   int cyc      = 0;

   assign bus.req_valid = {drv_v[3], drv_v[2], drv_v[1], drv_v[0]};
   assign bus.req_a     = {drv_a[3], drv_a[2], drv_a[1], drv_a[0]};
   assign bus.req_b     = {drv_b[3], drv_b[2], drv_b[1], drv_b[0]};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference carry-less product, accumulated over the bits of a.
   function automatic logic [PROD_W-1:0] clmul(input logic [FIELD_W-1:0] a,
                                                input logic [FIELD_W-1:0] b);
      logic [PROD_W-1:0] r;
      r = '0;
      for (int i = 0; i < FIELD_W; i++) begin
         if (a[i]) r = r ^ ({130'd0, b} << i);
      end
      return r;
   endfunction

   function automatic logic [FIELD_W-1:0] rnd131();
      logic [159:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return t[FIELD_W-1:0];
   endfunction

   task automatic push_req(input int r, input logic [FIELD_W-1:0] a,
                           input logic [FIELD_W-1:0] b,
                           input logic [PROD_W-1:0] prod);
      exp_t e;
      qa[r].push_back(a);
      qb[r].push_back(b);
      e.id   = ID_W'(r);
      e.data = prod;
      exp_q.push_back(e);
   endtask

   // Requester model: each requester presents the head of its queue and holds
   // it until the cycle after the handshake.
   initial begin
      logic [NREQ-1:0] hs;
      for (int i = 0; i < NREQ; i++) begin
         drv_v[i] = 1'b0;
         drv_a[i] = '0;
         drv_b[i] = '0;
      end
      forever begin
         @(negedge clk);
         hs = bus.req_valid & bus.req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (hs[i] && qa[i].size() > 0) begin
               void'(qa[i].pop_front());
               void'(qb[i].pop_front());
            end
            if (qa[i].size() > 0) begin
               drv_v[i] = 1'b1;
               drv_a[i] = qa[i][0];
               drv_b[i] = qb[i][0];
            end else begin
               drv_v[i] = 1'b0;
            end
         end
      end
   end

   // Response scoreboard.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
         tot_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_rsp: got id=%0d data=%h, required no response",
                     bus.rsp_id, bus.rsp_data);
         end else begin
            e = exp_q.pop_front();
            if (bus.rsp_data !== e.data)
               $display("FAIL rsp_data: got %h, required %h", bus.rsp_data, e.data);
            else pass_cnt++;
            tot_cnt++;
            if (bus.rsp_id !== e.id)
               $display("FAIL rsp_id: got %0d, required %0d", bus.rsp_id, e.id);
            else pass_cnt++;
         end
      end
   end

   task automatic wait_drain(output bit ok);
      bit empty;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         empty = (exp_q.size() == 0);
         for (int i = 0; i < NREQ; i++) if (qa[i].size() != 0) empty = 1'b0;
         if (empty && !bus.rsp_valid && !bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      bus.rsp_ready = 1'b1;
      exp_q.delete();
      for (int i = 0; i < NREQ; i++) begin
         qa[i].delete();
         qb[i].delete();
      end
      repeat (3) @(negedge clk);
      tot_cnt++;
      if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b, required 0", bus.rsp_valid);
      else pass_cnt++;
      tot_cnt++;
      if (bus.rsp_data !== '0) $display("FAIL reset_rsp_data: got %h, required 0", bus.rsp_data);
      else pass_cnt++;
      tot_cnt++;
      if (bus.rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d, required 0", bus.rsp_id);
      else pass_cnt++;
      tot_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", bus.busy);
      else pass_cnt++;
      tot_cnt++;
      if (bus.req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b, required 0000", bus.req_ready);
      else pass_cnt++;
`ifdef OBS_SCHED_PERF_EN
      tot_cnt++;
      if (perf_done !== 32'd0 || perf_stall !== 32'd0)
         $display("FAIL reset_perf: got done=%0d stall=%0d, required 0/0", perf_done, perf_stall);
      else pass_cnt++;
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int acc;
      int lat;
      bit seen;
      bit ok;
      logic [PROD_W-1:0] alt;
      logic [FIELD_W-1:0] ones;

      // T1: 1*1, with accept-to-valid latency
      push_req(0, 131'd1, 131'd1, 261'd1);
      seen = 1'b0;
      acc  = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (bus.req_valid[0] && bus.req_ready[0]) begin
            seen = 1'b1;
            acc  = cyc;
         end
      end
      tot_cnt++;
      if (!seen) $display("FAIL t1_accept: got no grant to requester 0, required grant within 20 cycles");
      else pass_cnt++;
      seen = 1'b0;
      lat  = -1;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            seen = 1'b1;
            lat  = cyc - acc;
         end
      end
      tot_cnt++;
      if (lat != 3) $display("FAIL t1_latency: got %0d, required 3", lat);
      else pass_cnt++;
      wait_drain(ok);
      tot_cnt++;
      if (!ok) $display("FAIL t1_drain: got timeout, required idle");
      else pass_cnt++;

      // T2: (x+1)^2 = x^2+1
      push_req(1, 131'd3, 131'd3, 261'd5);
      wait_drain(ok);
      tot_cnt++;
      if (!ok) $display("FAIL t2_drain: got timeout, required idle");
      else pass_cnt++;

      // T3: all-ones squared: cross terms cancel, only even powers remain
      ones = '1;
      alt  = '0;
      for (int i = 0; i < PROD_W; i += 2) alt[i] = 1'b1;
      push_req(2, ones, ones, alt);
      wait_drain(ok);
      tot_cnt++;
      if (!ok) $display("FAIL t3_drain: got timeout, required idle");
      else pass_cnt++;
   endtask

   task automatic test_round_robin();
      logic [FIELD_W-1:0] a;
      logic [FIELD_W-1:0] b;
      bit ok;
      int order [4] = '{3, 0, 1, 2};
      test_reset();
      a = rnd131(); b = rnd131(); push_req(0, a, b, clmul(a, b));
      a = rnd131(); b = rnd131(); push_req(2, a, b, clmul(a, b));
      wait_drain(ok);
      tot_cnt++;
      if (!ok) $display("FAIL rr_pair_drain: got timeout, required idle");
      else pass_cnt++;
      // Queue all four in one timestep; scoreboard order encodes expected grants.
      begin
         logic [FIELD_W-1:0] va [4];
         logic [FIELD_W-1:0] vb [4];
         exp_t e;
         for (int i = 0; i < 4; i++) begin
            va[i] = rnd131();
            vb[i] = rnd131();
            qa[i].push_back(va[i]);
            qb[i].push_back(vb[i]);
         end
         for (int k = 0; k < 4; k++) begin
            e.id   = ID_W'(order[k]);
            e.data = clmul(va[order[k]], vb[order[k]]);
            exp_q.push_back(e);
         end
      end
      wait_drain(ok);
      tot_cnt++;
      if (!ok) $display("FAIL rr_all_drain: got timeout, required idle");
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int acc [$];
      logic [FIELD_W-1:0] a;
      logic [FIELD_W-1:0] b;
      bit ok;
      for (int i = 0; i < 3; i++) begin
         a = rnd131();
         b = rnd131();
         push_req(1, a, b, clmul(a, b));
      end
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus.req_valid[1] && bus.req_ready[1]) acc.push_back(cyc);
      end
      tot_cnt++;
      if (acc.size() != 3) $display("FAIL b2b_grants: got %0d, required 3", acc.size());
      else pass_cnt++;
      for (int i = 1; i < acc.size(); i++) begin
         tot_cnt++;
         if (acc[i] - acc[i-1] != 4)
            $display("FAIL b2b_spacing: got %0d, required 4", acc[i] - acc[i-1]);
         else pass_cnt++;
      end
      wait_drain(ok);
      tot_cnt++;
      if (!ok) $display("FAIL b2b_drain: got timeout, required idle");
      else pass_cnt++;
   endtask

   task automatic test_stall();
      logic [FIELD_W-1:0] a;
      logic [FIELD_W-1:0] b;
      logic [PROD_W-1:0]  prod;
      bit seen;
      bit ok;
      test_reset();
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      a = rnd131();
      b = rnd131();
      prod = clmul(a, b);
      push_req(3, a, b, prod);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (bus.req_valid[3] && bus.req_ready[3]) seen = 1'b1;
      end
      tot_cnt++;
      if (!seen) $display("FAIL stall_accept: got no grant to requester 3, required grant");
      else pass_cnt++;
      push_req(0, rnd131(), 131'd1, 261'd0);
      // fix the expected product of the pending requester 0 entry
      exp_q[exp_q.size()-1].data = {130'd0, qa[0][qa[0].size()-1]};
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (bus.rsp_valid) seen = 1'b1;
      end
      tot_cnt++;
      if (!seen) $display("FAIL stall_rsp: got no rsp_valid, required rsp_valid");
      else pass_cnt++;
      for (int k = 0; k < 5; k++) begin
         tot_cnt++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== prod || bus.rsp_id !== 2'd3)
            $display("FAIL stall_hold: got valid=%b id=%0d data=%h, required valid=1 id=3 data=%h",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data, prod);
         else pass_cnt++;
         tot_cnt++;
         if (bus.req_ready !== 4'b0000)
            $display("FAIL stall_req_ready: got %b, required 0000", bus.req_ready);
         else pass_cnt++;
         if (k < 4) @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      tot_cnt++;
      if (bus.req_ready !== 4'b0001)
         $display("FAIL stall_next_grant: got %b, required 0001", bus.req_ready);
      else pass_cnt++;
`ifdef OBS_SCHED_PERF_EN
      tot_cnt++;
      if (perf_stall !== 32'd5) $display("FAIL perf_stall: got %0d, required 5", perf_stall);
      else pass_cnt++;
      tot_cnt++;
      if (perf_done !== 32'd1) $display("FAIL perf_done: got %0d, required 1", perf_done);
      else pass_cnt++;
`endif
      wait_drain(ok);
      tot_cnt++;
      if (!ok) $display("FAIL stall_drain: got timeout, required idle");
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_op();
      logic [FIELD_W-1:0] a;
      logic [FIELD_W-1:0] b;
      bit seen;
      bit ok;
      logic [NREQ-1:0] first;
      a = rnd131();
      b = rnd131();
      push_req(1, a, b, clmul(a, b));
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (bus.req_valid[1] && bus.req_ready[1]) seen = 1'b1;
      end
      tot_cnt++;
      if (!seen) $display("FAIL rst_mid_accept: got no grant to requester 1, required grant");
      else pass_cnt++;
      @(posedge clk);
      #1;
      tot_cnt++;
      if (bus.busy !== 1'b1) $display("FAIL rst_mid_busy_before: got %b, required 1", bus.busy);
      else pass_cnt++;
      rst_n = 1'b0;
      void'(exp_q.pop_back());
      #1;
      tot_cnt++;
      if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0)
         $display("FAIL rst_mid_clear: got busy=%b rsp_valid=%b, required 0/0", bus.busy, bus.rsp_valid);
      else pass_cnt++;
      a = rnd131(); b = rnd131(); push_req(0, a, b, clmul(a, b));
      qa[3].push_back(b);
      qb[3].push_back(a);
      begin
         exp_t e;
         e.id   = 2'd3;
         e.data = clmul(a, b);
         exp_q.push_back(e);
      end
      repeat (2) @(negedge clk);
      tot_cnt++;
      if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0)
         $display("FAIL rst_mid_hold: got req_ready=%b rsp_valid=%b, required 0000/0",
                  bus.req_ready, bus.rsp_valid);
      else pass_cnt++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen  = 1'b0;
      first = '0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if ((bus.req_valid & bus.req_ready) != '0) begin
            seen  = 1'b1;
            first = bus.req_valid & bus.req_ready;
         end
      end
      tot_cnt++;
      if (first !== 4'b0001) $display("FAIL rst_mid_first_grant: got %b, required 0001", first);
      else pass_cnt++;
      wait_drain(ok);
      tot_cnt++;
      if (!ok) $display("FAIL rst_mid_drain: got timeout, required idle");
      else pass_cnt++;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.rsp_ready = 1'b1;
      test_reset();
      test_basic();
      test_round_robin();
      test_back_to_back();
      test_stall();
      test_reset_mid_op();
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
